// File: rtl/count_run_scheduler.sv
// Two-requester round-robin scheduler that owns the shared LED counter for one run at a time.
// Each run counts leds from 0 up to the owner's latched limit, then pulses done for one cycle.
module count_run_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             dividedClock,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] limit0,
    input  logic [WIDTH-1:0] limit1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] leds
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             owner_next;
    logic             last_served;
    logic             last_served_next;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_next;
    logic [WIDTH-1:0] leds_next;
    logic             winner;

    // last_served resets to 1 so requester 0 wins the first contested arbitration.
    always_ff @(posedge dividedClock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            target      <= '0;
            leds        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state       <= state_next;
            owner       <= owner_next;
            last_served <= last_served_next;
            target      <= target_next;
            leds        <= leds_next;
        end
    end

    // A lone request wins outright; a tie goes to whoever was not served last.
    assign winner = (req == 2'b11) ? ~last_served : req[1];

    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no latch is inferred.
        state_next       = state;
        owner_next       = owner;
        last_served_next = last_served;
        target_next      = target;
        leds_next        = leds;

        case (state)
            IDLE: begin
                leds_next = '0;
                if (req != 2'b00) begin
                    owner_next  = winner;
                    target_next = winner ? limit1 : limit0;
                    state_next  = COUNT;
                end
            end
            COUNT: begin
                // Withdrawal beats completion: an abort never produces a done pulse.
                if (!req[owner]) begin
                    state_next       = IDLE;
                    leds_next        = '0;
                    last_served_next = owner;
                end else if (leds == target) begin
                    state_next = DONE;
                end else begin
                    leds_next = leds + WIDTH'(1);
                end
            end
            DONE: begin
                state_next       = IDLE;
                leds_next        = '0;
                last_served_next = owner;
            end
            default: begin
                state_next = IDLE;
                leds_next  = '0;
            end
        endcase
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        grant = 2'b00;
        done  = 2'b00;
        if (state == COUNT || state == DONE) begin
            grant[owner] = 1'b1;
        end
        if (state == DONE) begin
            done[owner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_count_run_scheduler.sv
// Self-checking bench for count_run_scheduler: directed scenarios with literal expectations,
// then randomized requests/limits compared every cycle against a run-position reference model.
module tb_count_run_scheduler;

    localparam int WIDTH = 4;

    logic             dividedClock = 1'b0;
    logic             rst          = 1'b1;
    logic [1:0]       req          = 2'b00;
    logic [WIDTH-1:0] limit0       = '0;
    logic [WIDTH-1:0] limit1       = '0;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] leds;

    int tests_run = 0;
    int tests_failed = 0;
    bit cmp_en = 1'b0;

    count_run_scheduler #(.WIDTH(WIDTH)) dut (
        .dividedClock(dividedClock),
        .rst(rst),
        .req(req),
        .limit0(limit0),
        .limit1(limit1),
        .grant(grant),
        .done(done),
        .busy(busy),
        .leds(leds)
    );

    always #5 dividedClock = ~dividedClock;

    // Reference model: a run is "active" with position pos; positions 0..T show leds=pos,
    // position T+1 is the done cycle. No run means everything reads zero.
    bit m_active = 1'b0;
    bit m_owner  = 1'b0;
    bit m_last   = 1'b1;
    int m_target = 0;
    int m_pos    = 0;

    function automatic logic [1:0] exp_grant();
        return m_active ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    endfunction

    function automatic logic [1:0] exp_done();
        return (m_active && m_pos == m_target + 1) ? exp_grant() : 2'b00;
    endfunction

    function automatic int exp_leds();
        if (!m_active) return 0;
        return (m_pos > m_target) ? m_target : m_pos;
    endfunction

    always @(posedge dividedClock or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_owner  <= 1'b0;
            m_last   <= 1'b1;
            m_target <= 0;
            m_pos    <= 0;
        end else if (!m_active) begin
            if (req != 2'b00) begin
                bit w;
                w = (req == 2'b11) ? !m_last : (req == 2'b10);
                m_active <= 1'b1;
                m_owner  <= w;
                m_target <= w ? int'(limit1) : int'(limit0);
                m_pos    <= 0;
            end
        end else if (m_pos <= m_target) begin
            if (!req[m_owner]) begin
                m_active <= 1'b0;
                m_last   <= m_owner;
            end else begin
                m_pos <= m_pos + 1;
            end
        end else begin
            m_active <= 1'b0;
            m_last   <= m_owner;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge dividedClock) begin
        if (cmp_en && !rst) begin
            check("model_grant", 32'(grant), 32'(exp_grant()));
            check("model_done",  32'(done),  32'(exp_done()));
            check("model_busy",  32'(busy),  32'(m_active));
            check("model_leds",  32'(leds),  32'(exp_leds()));
        end
    end

    // Advance one rising edge and settle just after the following falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge dividedClock);
            @(negedge dividedClock);
            #1;
        end
    endtask

    task automatic expect_out(input string name, input logic [1:0] g, input logic [1:0] d,
                              input logic [WIDTH-1:0] l);
        check({name, "_grant"}, 32'(grant), 32'(g));
        check({name, "_done"},  32'(done),  32'(d));
        check({name, "_leds"},  32'(leds),  32'(l));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(negedge dividedClock);
        #1;
    endtask

    initial begin
        @(negedge dividedClock);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        expect_out("reset", 2'b00, 2'b00, 4'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Single requester, limit 5.
        limit0 = 4'd5;
        req = 2'b01;
        tick();
        expect_out("r0_grant", 2'b01, 2'b00, 4'd0);
        tick(5);
        expect_out("r0_at5", 2'b01, 2'b00, 4'd5);
        check("pin_model_leds5", 32'(exp_leds()), 32'd5);
        tick();
        expect_out("r0_done", 2'b01, 2'b01, 4'd5);
        req = 2'b00;
        tick();
        expect_out("r0_after", 2'b00, 2'b00, 4'd0);

        // Both requesters held: r0 first after reset, then r1, then r0.
        do_reset();
        limit0 = 4'd2;
        limit1 = 4'd3;
        req = 2'b11;
        tick();
        expect_out("rr_r0", 2'b01, 2'b00, 4'd0);
        tick(3);
        expect_out("rr_r0_done", 2'b01, 2'b01, 4'd2);
        tick();
        expect_out("rr_idle", 2'b00, 2'b00, 4'd0);
        tick();
        expect_out("rr_r1", 2'b10, 2'b00, 4'd0);
        tick(4);
        expect_out("rr_r1_done", 2'b10, 2'b10, 4'd3);
        tick(2);
        expect_out("rr_r0_again", 2'b01, 2'b00, 4'd0);
        check("pin_model_grant", 32'(exp_grant()), 32'd1);
        req = 2'b00;
        tick();

        // Target 0, then full-scale target 15 without wrap.
        limit1 = 4'd0;
        req = 2'b10;
        tick();
        expect_out("t0_count", 2'b10, 2'b00, 4'd0);
        tick();
        expect_out("t0_done", 2'b10, 2'b10, 4'd0);
        req = 2'b00;
        tick();
        limit1 = 4'd15;
        req = 2'b10;
        tick(16);
        expect_out("t15_top", 2'b10, 2'b00, 4'd15);
        tick();
        expect_out("t15_done", 2'b10, 2'b10, 4'd15);
        req = 2'b00;
        tick();

        // Abort at leds=4 with r1 pending.
        limit0 = 4'd9;
        req = 2'b01;
        tick(5);
        expect_out("ab_at4", 2'b01, 2'b00, 4'd4);
        req = 2'b10;
        tick();
        expect_out("ab_drop", 2'b00, 2'b00, 4'd0);
        tick();
        expect_out("ab_r1", 2'b10, 2'b00, 4'd0);
        req = 2'b00;
        tick();

        // Asynchronous reset at leds=7.
        req = 2'b01;
        tick(8);
        expect_out("rs_at7", 2'b01, 2'b00, 4'd7);
        rst = 1'b1;
        #1;
        expect_out("rs_async", 2'b00, 2'b00, 4'd0);
        check("rs_busy", 32'(busy), 32'd0);
        req = 2'b11;
        limit1 = 4'd1;
        #1;
        rst = 1'b0;
        tick();
        expect_out("rs_r0_first", 2'b01, 2'b00, 4'd0);
        req = 2'b00;
        tick();

        // Limit changed mid-run has no effect.
        limit0 = 4'd3;
        req = 2'b01;
        tick(2);
        limit0 = 4'd12;
        tick(2);
        expect_out("lim_at3", 2'b01, 2'b00, 4'd3);
        tick();
        expect_out("lim_done", 2'b01, 2'b01, 4'd3);
        req = 2'b00;
        tick();

        // Randomized phase with an asynchronous reset pulse partway through.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
            if ($urandom_range(0, 3) == 0) limit0 = WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) limit1 = WIDTH'($urandom_range(0, 15));
            if (i == 700) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
